seg_scan_rx: RTL and testbench

SEG_SCAN_RX -- requirements
Module: seg_scan_rx

---
 rtl/seg_scan_rx_if.sv | 27 ++
 rtl/seg_scan_rx.sv | 152 +++++++++++++++
 tb/tb_seg_scan_rx.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_rx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_rx_if : multiplexed seven-segment scan bus and decoded outputs  |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
interface seg_scan_rx_if;
  logic [5:0]  i_seg_enb;
  logic [6:0]  i_seg;
  logic        i_seg_dp;
  logic [23:0] o_digits;
  logic [5:0]  o_dp;
  logic [5:0]  o_valid_mask;
  logic        o_frame_done;
  logic        o_err;
  logic [7:0]  o_frame_cnt;

  modport master (
    output i_seg_enb, i_seg, i_seg_dp,
    input  o_digits, o_dp, o_valid_mask, o_frame_done, o_err, o_frame_cnt
  );

  modport slave (
    input  i_seg_enb, i_seg, i_seg_dp,
    output o_digits, o_dp, o_valid_mask, o_frame_done, o_err, o_frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_rx : receiver for a 6-digit multiplexed seven-segment scan bus  |
// |   SEG_SCAN_RX_STABLE_EN enables the STABLE_CYC sample-stability filter.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module seg_scan_rx #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_rx_if.slave  bus
);

`ifdef SEG_SCAN_RX_STABLE_EN
  localparam int unsigned c_THR = STABLE_CYC;
`else
  localparam int unsigned c_THR = (STABLE_CYC != 0) ? 1 : 1;
`endif
  localparam logic [8:0]  c_THR_W   = c_THR[8:0];
  localparam logic [8:0]  c_SAT     = c_THR_W + 9'd1;
  localparam logic [13:0] c_SMP_RST = {6'h3F, 7'h00, 1'b0};

  typedef enum logic [0:0] {SYNC_WAIT = 1'b0, CAPTURE = 1'b1} state_t;

  logic [13:0] w_in;
  logic [13:0] r_sync1;
  logic [13:0] r_smp;
  logic [8:0]  r_cnt;
  logic [5:0]  w_low;
  logic        w_fire;
  logic        w_one;
  logic        w_multi;
  logic [2:0]  w_slot;
  logic [4:0]  w_dec;

  state_t      r_state;
  logic [2:0]  r_exp;
  logic [23:0] r_digits;
  logic [5:0]  r_dp;
  logic [5:0]  r_valid;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_fcnt;

  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1111110: res = {1'b1, 4'd0};
      7'b0110000: res = {1'b1, 4'd1};
      7'b1101101: res = {1'b1, 4'd2};
      7'b1111001: res = {1'b1, 4'd3};
      7'b0110011: res = {1'b1, 4'd4};
      7'b1011011: res = {1'b1, 4'd5};
      7'b1011111: res = {1'b1, 4'd6};
      7'b1110000: res = {1'b1, 4'd7};
      7'b1111111: res = {1'b1, 4'd8};
      7'b1110011: res = {1'b1, 4'd9};
      7'b0000000: res = {1'b0, 4'hF};
      default:    res = {1'b0, 4'hE};
    endcase
    return res;
  endfunction

  assign w_in = {bus.i_seg_enb, bus.i_seg, bus.i_seg_dp};

  // r_cnt is the run length of the current synchronized sample, saturating
  // just above the threshold so the capture strobe fires exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= c_SMP_RST;
      r_smp   <= c_SMP_RST;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= w_in;
      r_smp   <= r_sync1;
      if (r_sync1 != r_smp)
        r_cnt <= 9'd1;
      else if (r_cnt != c_SAT)
        r_cnt <= r_cnt + 9'd1;
    end
  end

  assign w_low   = ~r_smp[13:8];
  assign w_fire  = (r_cnt == c_THR_W);
  assign w_one   = (w_low != 6'd0) && ((w_low & (w_low - 6'd1)) == 6'd0);
  assign w_multi = (w_low != 6'd0) && !w_one;
  assign w_dec   = f_decode(r_smp[7:1]);

  always_comb begin
    w_slot = 3'd0;
    for (int k = 0; k < 6; k++)
      if (w_low[k]) w_slot = 3'(k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= SYNC_WAIT;
      r_exp    <= 3'd0;
      r_digits <= {6{4'hF}};
      r_dp     <= '0;
      r_valid  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_fcnt   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_fire && w_multi) begin
        r_err   <= 1'b1;
        r_state <= SYNC_WAIT;
        r_exp   <= 3'd0;
      end else if (w_fire && w_one) begin
        r_digits[{w_slot, 2'b00} +: 4] <= w_dec[3:0];
        r_dp[w_slot]                   <= r_smp[0];
        r_valid[w_slot]                <= w_dec[4];
        if (r_state == SYNC_WAIT) begin
          if (w_slot == 3'd0) begin
            r_exp   <= 3'd1;
            r_state <= CAPTURE;
          end
        end else if (w_slot == r_exp) begin
          if (r_exp == 3'd5) begin
            r_done <= 1'b1;
            r_fcnt <= r_fcnt + 8'd1;
            r_exp  <= 3'd0;
          end else begin
            r_exp <= r_exp + 3'd1;
          end
        end else begin
          // Out-of-order: a stray slot 0 restarts the frame in place.
          r_err <= 1'b1;
          if (w_slot == 3'd0) begin
            r_exp <= 3'd1;
          end else begin
            r_state <= SYNC_WAIT;
            r_exp   <= 3'd0;
          end
        end
      end
    end
  end

  assign bus.o_digits     = r_digits;
  assign bus.o_dp         = r_dp;
  assign bus.o_valid_mask = r_valid;
  assign bus.o_frame_done = r_done;
  assign bus.o_err        = r_err;
  assign bus.o_frame_cnt  = r_fcnt;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_rx.sv
`default_nettype none
// Self-checking bench for seg_scan_rx: vector table, directed corner cases and
// randomized scans compared every cycle against a history-based reference model.
module tb_seg_scan_rx;
`ifdef SEG_SCAN_RX_STABLE_EN
  localparam int THR = 4;
`else
  localparam int THR = 1;
`endif
  localparam logic [13:0] RSTV = {6'h3F, 7'h00, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_rx_if bus();
  seg_scan_rx #(.STABLE_CYC(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  int n_err  = 0;

  logic [13:0] hist [0:65535];
  int          ecount = 0;
  logic [6:0]  segtab [10];

  logic [23:0] m_dig;
  logic [5:0]  m_dp;
  logic [5:0]  m_valid;
  logic        m_done;
  logic        m_err;
  logic [7:0]  m_fcnt;
  bit          m_inframe;
  int          m_exp;

  typedef struct {
    logic [2:0] slot;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] nib;
    logic       val;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [13:0] hget(input int k);
    return (k < 0) ? RSTV : hist[k];
  endfunction

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++)
      if (s == segtab[i]) return {1'b1, 4'(i)};
    return (s == 7'd0) ? {1'b0, 4'hF} : {1'b0, 4'hE};
  endfunction

  task automatic model_reset();
    m_dig = {6{4'hF}}; m_dp = '0; m_valid = '0;
    m_done = 1'b0; m_err = 1'b0; m_fcnt = '0;
    m_inframe = 1'b0; m_exp = 0;
  endtask

  // A sample is accepted two edges after it was sampled, once its run of
  // identical samples is exactly THR long.
  task automatic model_edge();
    logic [13:0] s;
    logic [5:0]  low;
    logic [4:0]  d;
    int run, k, slot;
    hist[ecount] = rst_n ? {bus.i_seg_enb, bus.i_seg, bus.i_seg_dp} : RSTV;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst_n) begin
      s = hget(ecount - 2);
      run = 0;
      k = ecount - 2;
      while (run <= THR && hget(k) == s) begin run++; k--; end
      low = ~s[13:8];
      if (run == THR && low != 6'd0) begin
        if ($countones(low) > 1) begin
          m_err = 1'b1; m_inframe = 1'b0; m_exp = 0;
        end else begin
          slot = 0;
          for (int i = 0; i < 6; i++) if (low[i]) slot = i;
          d = ref_decode(s[7:1]);
          m_dig[slot*4 +: 4] = d[3:0];
          m_valid[slot] = d[4];
          m_dp[slot] = s[0];
          if (!m_inframe) begin
            if (slot == 0) begin m_inframe = 1'b1; m_exp = 1; end
          end else if (slot == m_exp) begin
            if (m_exp == 5) begin m_done = 1'b1; m_fcnt = m_fcnt + 8'd1; m_exp = 0; end
            else m_exp++;
          end else begin
            m_err = 1'b1;
            if (slot == 0) m_exp = 1;
            else begin m_inframe = 1'b0; m_exp = 0; end
          end
        end
      end
    end
    ecount++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("cycle_outputs",
          {bus.o_digits, bus.o_dp, bus.o_valid_mask, bus.o_frame_done, bus.o_err, bus.o_frame_cnt},
          {m_dig, m_dp, m_valid, m_done, m_err, m_fcnt});
    n_done += int'(bus.o_frame_done);
    n_err  += int'(bus.o_err);
  endtask

  task automatic drive(input logic [5:0] enb, input logic [6:0] seg, input logic dp);
    bus.i_seg_enb = enb; bus.i_seg = seg; bus.i_seg_dp = dp;
  endtask

  task automatic hold(input logic [5:0] enb, input logic [6:0] seg, input logic dp, input int n);
    drive(enb, seg, dp);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [5:0] sel(input int slot);
    logic [5:0] one;
    one = 6'b000001;
    return ~(one << slot);
  endfunction

  task automatic scan_frame(input int hold_n);
    for (int s = 0; s < 6; s++) hold(sel(s), segtab[s+1], 1'b0, hold_n);
  endtask

  initial begin
    int d0, e0;
    segtab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};
    tbl[0]  = '{3'd0, 7'b0110000, 1'b0, 4'd1, 1'b1};
    tbl[1]  = '{3'd1, 7'b1101101, 1'b1, 4'd2, 1'b1};
    tbl[2]  = '{3'd2, 7'b1111001, 1'b0, 4'd3, 1'b1};
    tbl[3]  = '{3'd3, 7'b0110011, 1'b1, 4'd4, 1'b1};
    tbl[4]  = '{3'd4, 7'b1011011, 1'b0, 4'd5, 1'b1};
    tbl[5]  = '{3'd5, 7'b1011111, 1'b1, 4'd6, 1'b1};
    tbl[6]  = '{3'd0, 7'b1111110, 1'b0, 4'd0, 1'b1};
    tbl[7]  = '{3'd1, 7'b1110000, 1'b0, 4'd7, 1'b1};
    tbl[8]  = '{3'd2, 7'b1111111, 1'b0, 4'd8, 1'b1};
    tbl[9]  = '{3'd3, 7'b1110011, 1'b0, 4'd9, 1'b1};
    tbl[10] = '{3'd4, 7'b1000001, 1'b0, 4'hE, 1'b0};
    tbl[11] = '{3'd5, 7'b0000000, 1'b0, 4'hF, 1'b0};

    model_reset();
    drive(6'h3F, 7'd0, 1'b0);
    tick(); tick();
    check("reset_state",
          {bus.o_digits, bus.o_dp, bus.o_valid_mask, bus.o_frame_done, bus.o_err, bus.o_frame_cnt},
          {24'hFFFFFF, 6'd0, 6'd0, 1'b0, 1'b0, 8'd0});
    rst_n = 1'b1;
    hold(6'h3F, 7'd0, 1'b0, 3);

    // Table: two full in-order frames, covering every decode class.
    for (int i = 0; i < 12; i++) begin
      hold(sel(int'(tbl[i].slot)), tbl[i].seg, tbl[i].dp, THR + 6);
      check("tbl_nibble", bus.o_digits[tbl[i].slot*4 +: 4], tbl[i].nib);
      check("tbl_valid", bus.o_valid_mask[tbl[i].slot], tbl[i].val);
      check("tbl_dp", bus.o_dp[tbl[i].slot], tbl[i].dp);
      if (i == 5) begin
        check("frame1_digits", bus.o_digits, 24'h654321);
        check("frame1_valid", bus.o_valid_mask, 6'h3F);
        check("frame1_dp", bus.o_dp, 6'b101010);
        check("frame1_cnt", bus.o_frame_cnt, 8'd1);
        check("frame1_done_pulses", n_done, 1);
      end
    end
    check("frame2_cnt", bus.o_frame_cnt, 8'd2);
    check("frame2_valid", bus.o_valid_mask, 6'b001111);

    // Short hold is ignored; a THR-cycle hold lands exactly 2+THR cycles later.
    hold(6'h3F, 7'd0, 1'b0, 6);
    hold(sel(0), segtab[5], 1'b0, THR - 1);
    hold(6'h3F, 7'd0, 1'b0, 8);
    check("short_hold_nocap", bus.o_digits[3:0], 4'd0);
    hold(sel(0), segtab[5], 1'b0, THR);
    drive(6'h3F, 7'd0, 1'b0);
    tick();
    check("latency_early", bus.o_digits[3:0], 4'd0);
    tick();
    check("latency_exact", bus.o_digits[3:0], 4'd5);
    hold(6'h3F, 7'd0, 1'b0, 4);

    // Out-of-order 0,1,3 then trailing 4,5: one error, no frame.
    hold(sel(0), segtab[1], 1'b0, THR + 6);
    hold(sel(1), segtab[2], 1'b0, THR + 6);
    d0 = n_done; e0 = n_err;
    hold(sel(3), segtab[4], 1'b0, THR + 6);
    hold(sel(4), segtab[5], 1'b0, THR + 6);
    hold(sel(5), segtab[6], 1'b0, THR + 6);
    check("ooo_err_pulses", n_err - e0, 1);
    check("ooo_no_done", n_done - d0, 0);
    scan_frame(THR + 6);
    check("resync_done", n_done - d0, 1);
    check("resync_digits", bus.o_digits, 24'h654321);

    // Multi-hot select: single error, digits untouched.
    e0 = n_err;
    hold(6'b111100, 7'b1111111, 1'b1, 10);
    check("multihot_err", n_err - e0, 1);
    check("multihot_digits", bus.o_digits, 24'h654321);
    hold(6'h3F, 7'd0, 1'b0, 4);

    // Randomized scanning.
    for (int n = 0; n < 400; n++) begin
      int kind;
      logic [5:0] e;
      logic [6:0] sg;
      kind = int'($urandom_range(0, 9));
      if (kind < 6) e = sel((n % 7 == 6) ? int'($urandom_range(0, 5)) : n % 6);
      else if (kind == 6) e = 6'h3F;
      else e = 6'($urandom);
      sg = ($urandom_range(0, 3) == 0) ? 7'($urandom) : segtab[$urandom_range(0, 9)];
      hold(e, sg, 1'($urandom), int'($urandom_range(1, THR + 3)));
    end

    // 256 frames wrap the counter; reset mid frame 257.
    drive(6'h3F, 7'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    hist[ecount - 1] = RSTV;
    tick(); tick();
    rst_n = 1'b1;
    hold(6'h3F, 7'd0, 1'b0, 4);
    d0 = n_done;
    for (int f = 0; f < 256; f++) scan_frame(THR + 2);
    check("wrap_cnt", bus.o_frame_cnt, 8'd0);
    check("wrap_done_pulses", n_done - d0, 256);
    hold(sel(0), segtab[1], 1'b0, THR + 2);
    hold(sel(1), segtab[2], 1'b0, THR + 2);
    drive(sel(0), segtab[3], 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    hist[ecount - 1] = RSTV;
    check("midframe_reset",
          {bus.o_digits, bus.o_dp, bus.o_valid_mask, bus.o_frame_done, bus.o_err, bus.o_frame_cnt},
          {24'hFFFFFF, 6'd0, 6'd0, 1'b0, 1'b0, 8'd0});
    tick(); tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < THR + 1; i++) tick();
    check("post_reset_nocap", bus.o_digits[3:0], 4'hF);
    tick();
    check("post_reset_cap", bus.o_digits[3:0], 4'd3);
    hold(6'h3F, 7'd0, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
